// File: rtl/pipelined_rca_pkg.sv
// Shared configuration for the pipelined ripple-carry adder/subtractor.
// Holds the default operand width, the default pipeline depth and the
// slice width derived from them. No ports; imported by rca_slice and
// pipelined_rca_addsub.
package pipelined_rca_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int STAGES_DEF = 4;
  localparam int SLICE_W    = WIDTH_DEF / STAGES_DEF;

endpackage

// File: rtl/rca_slice.sv
// Combinational W-bit ripple-carry adder slice.
// Ports:
//   a, b   : slice operands (b already inverted by the caller for subtract)
//   cin    : carry into the slice LSB
//   sum    : slice sum
//   cout   : carry out of the slice MSB
//   c_msb  : carry into the slice MSB (used for signed-overflow detection)
module rca_slice
  import pipelined_rca_pkg::*;
#(
  parameter int W = SLICE_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  always_comb begin
    logic c;
    sum   = '0;
    c_msb = 1'b0;
    // NOTE: the ripple carry is a local variable updated with blocking
    // assignments so each bit sees the carry produced by the bit below.
    c     = cin;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) c_msb = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/pipelined_rca_addsub.sv
// Pipelined ripple-carry adder/subtractor with valid/ready handshake.
// Stage k adds slice k of the operands using the carry registered by
// stage k-1; stage 0 uses the effective carry-in. The last stage's result
// lands directly in the output registers, giving a latency of STAGES cycles.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : input handshake (in_ready = pipeline advance)
//   a, b, cin, sub      : operands, carry/borrow-in, 0=add 1=subtract
//   out_valid/out_ready : output handshake
//   sum, carry, overflow: result, carry-out (not-borrow), signed overflow
module pipelined_rca_addsub
  import pipelined_rca_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STAGES = STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int SW = WIDTH / STAGES;
  // Number of intermediate stage registers; the last stage feeds the outputs.
  localparam int NQ = (STAGES > 1) ? STAGES - 1 : 1;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_rca_addsub: WIDTH must be a multiple of STAGES");
  end

  // Operands travel whole; sum fills in one slice per stage.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;      // effective (possibly inverted) B
    logic [WIDTH-1:0] sum;
    logic             c;      // carry out of the slices done so far
    logic             c_msb;  // carry into the most recent slice's MSB
  } stage_t;

  stage_t            stage_q [NQ];
  stage_t            stage_d [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [WIDTH-1:0]  sum_q;
  logic              carry_q;
  logic              ovf_q;
  logic              advance;

  // Reset forces advance so in_ready reads 1 while rst_n is low.
  assign advance   = !rst_n || !vld_q[STAGES-1] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_q[STAGES-1];
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t          src;
    stage_t          nxt;
    logic [SW-1:0]   s_sum;
    logic            s_cout;
    logic            s_msb;

    if (k == 0) begin : g_first
      // Subtract as a + ~b + ~cin so cin doubles as borrow-in.
      assign src = '{a: a, b: (sub ? ~b : b), sum: '0,
                     c: (sub ? ~cin : cin), c_msb: 1'b0};
    end else begin : g_next
      assign src = stage_q[k-1];
    end

    rca_slice #(.W(SW)) u_slice (
      .a     (src.a[k*SW +: SW]),
      .b     (src.b[k*SW +: SW]),
      .cin   (src.c),
      .sum   (s_sum),
      .cout  (s_cout),
      .c_msb (s_msb)
    );

    always_comb begin
      nxt                   = src;
      nxt.sum[k*SW +: SW]   = s_sum;
      nxt.c                 = s_cout;
      nxt.c_msb             = s_msb;
    end

    assign stage_d[k] = nxt;
  end

  // NOTE: datapath stage registers have no reset; their contents are
  // qualified by the valid bits, which are reset below.
  always_ff @(posedge clk) begin
    if (advance) begin
      for (int k = 0; k < STAGES - 1; k++) stage_q[k] <= stage_d[k];
    end
  end

  // NOTE: state is updated with non-blocking assignments so every stage
  // samples its predecessor's pre-edge value and the whole pipe shifts together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (advance) begin
      // Bubbles enter as valid=0 when no beat is offered.
      vld_q   <= STAGES'({vld_q, in_valid});
      sum_q   <= stage_d[STAGES-1].sum;
      carry_q <= stage_d[STAGES-1].c;
      ovf_q   <= stage_d[STAGES-1].c ^ stage_d[STAGES-1].c_msb;
    end
  end

endmodule
